// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared types and codeword layout for the Hamming(7,4) serial transmitter
package hamming_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CW_BITS   = 7;
  localparam int DATA_BITS = 4;

  // Codeword vector index = codeword position - 1
  localparam int POS_P1 = 0;
  localparam int POS_P2 = 1;
  localparam int POS_D1 = 2;
  localparam int POS_P4 = 3;
  localparam int POS_D2 = 4;
  localparam int POS_D3 = 5;
  localparam int POS_D4 = 6;

endpackage

// File: rtl/hamming74_serial_tx_if.sv
// rtl/hamming74_serial_tx_if.sv - pin bundle of the transmitter: io_in (clk, rst_n, load, inject, d) and io_out
interface hamming74_serial_tx_if;

  logic [7:0] io_in;
  logic [7:0] io_out;

  modport master (output io_in, input io_out);
  modport slave  (input io_in, output io_out);

endinterface

// File: rtl/hamming74_enc.sv
// rtl/hamming74_enc.sv - combinational Hamming(7,4) encoder, positions 1..7 = p1 p2 d1 p4 d2 d3 d4
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [DATA_BITS-1:0] i_d,
  output logic [CW_BITS-1:0]   o_cw
);

  always_comb begin
    o_cw         = '0;
    o_cw[POS_P1] = i_d[0] ^ i_d[1] ^ i_d[3];
    o_cw[POS_P2] = i_d[0] ^ i_d[2] ^ i_d[3];
    o_cw[POS_D1] = i_d[0];
    o_cw[POS_P4] = i_d[1] ^ i_d[2] ^ i_d[3];
    o_cw[POS_D2] = i_d[1];
    o_cw[POS_D3] = i_d[2];
    o_cw[POS_D4] = i_d[3];
  end

endmodule

// File: rtl/hamming74_serial_tx.sv
// rtl/hamming74_serial_tx.sv - latches a nibble, encodes Hamming(7,4), shifts it out serially with frame/last strobes
// Optional macro ERROR_INJECT_EN: inject flips codeword position 3 (d1) in the transmitted bits only.
module hamming74_serial_tx
  import hamming_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int POS1_FIRST = 1
) (
  hamming74_serial_tx_if.slave io
);

  localparam logic [2:0] LAST_CNT = 3'(CW_BITS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  logic                 w_clk;
  logic                 w_rst_n;
  logic                 w_load;
  logic [DATA_BITS-1:0] w_d;
  logic [CW_BITS-1:0]   w_enc_cw;
  logic [CW_BITS-1:0]   w_tx_cw;
  logic [2:0]           w_enc_par;
  logic                 w_ready;

  state_t               r_state;
  state_t               w_next_state;
  logic [2:0]           r_cnt;
  logic [2:0]           w_next_cnt;
  logic [3:0]           r_gap;
  logic [3:0]           w_next_gap;
  logic [CW_BITS-1:0]   r_cw;
  logic [CW_BITS-1:0]   w_next_cw;
  logic [2:0]           r_par;
  logic [2:0]           w_next_par;
  logic                 r_ser;
  logic                 w_next_ser;
  logic                 r_frame;
  logic                 w_next_frame;
  logic                 r_last;
  logic                 w_next_last;
  logic                 r_done;
  logic                 w_next_done;

  assign w_clk   = io.io_in[0];
  assign w_rst_n = io.io_in[1];
  assign w_load  = io.io_in[2];
  assign w_d     = io.io_in[7:4];

  hamming74_enc u_enc (
    .i_d  (w_d),
    .o_cw (w_enc_cw)
  );

  assign w_enc_par = {w_enc_cw[POS_P4], w_enc_cw[POS_P2], w_enc_cw[POS_P1]};

`ifdef ERROR_INJECT_EN
  logic                 w_inject;
  logic [CW_BITS-1:0]   w_flip;

  assign w_inject = io.io_in[3];

  always_comb begin
    w_flip         = '0;
    w_flip[POS_D1] = w_inject;
  end

  assign w_tx_cw = w_enc_cw ^ w_flip;
`else
  logic w_unused_inject;

  assign w_unused_inject = io.io_in[3];
  assign w_tx_cw         = w_enc_cw;
`endif

  function automatic logic tx_bit(input logic [CW_BITS-1:0] cw, input logic [2:0] idx);
    if (POS1_FIRST != 0) begin
      return cw[idx];
    end
    return cw[LAST_CNT - idx];
  endfunction

  assign w_ready = (r_state == IDLE);

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_gap   = r_gap;
    w_next_cw    = r_cw;
    w_next_par   = r_par;
    w_next_ser   = 1'b0;
    w_next_frame = 1'b0;
    w_next_last  = 1'b0;
    w_next_done  = r_done;
    case (r_state)
      IDLE: begin
        if (w_load) begin
          // Bit 0 is registered on the accepting edge so it appears one cycle later
          w_next_state = SHIFT;
          w_next_cnt   = 3'd0;
          w_next_cw    = w_tx_cw;
          w_next_par   = w_enc_par;
          w_next_ser   = tx_bit(w_tx_cw, 3'd0);
          w_next_frame = 1'b1;
        end
      end
      SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_next_done  = ~r_done;
          w_next_gap   = 4'd0;
          w_next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          w_next_cnt  = r_cnt + 3'd1;
          w_next_ser  = tx_bit(r_cw, r_cnt + 3'd1);
          w_next_last = ((r_cnt + 3'd1) == LAST_CNT);
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) begin
          w_next_state = IDLE;
        end else begin
          w_next_gap = r_gap + 4'd1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_cnt   <= 3'd0;
      r_gap   <= 4'd0;
      r_cw    <= '0;
      r_par   <= 3'd0;
      r_ser   <= 1'b0;
      r_frame <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_cnt   <= w_next_cnt;
      r_gap   <= w_next_gap;
      r_cw    <= w_next_cw;
      r_par   <= w_next_par;
      r_ser   <= w_next_ser;
      r_frame <= w_next_frame;
      r_last  <= w_next_last;
      r_done  <= w_next_done;
    end
  end

  assign io.io_out = {r_done, r_par, r_last, w_ready, r_frame, r_ser};

endmodule

// File: tb/tb_hamming74_serial_tx.sv
// tb/tb_hamming74_serial_tx.sv - self-checking bench for hamming74_serial_tx (position-1-first and position-7-first builds)
module tb_hamming74_serial_tx;

  localparam int GAP = 2;

  typedef struct packed {
    logic ser;
    logic frame;
    logic last;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load0 = 1'b0;
  logic       load1 = 1'b0;
  logic       inject = 1'b0;
  logic [3:0] d0 = 4'd0;
  logic [3:0] d1v = 4'd0;
  logic [7:0] out0;
  logic [7:0] out1;

  int tests = 0;
  int fails = 0;

  hamming74_serial_tx_if bus0 ();
  hamming74_serial_tx_if bus1 ();

  assign bus0.io_in = {d0, inject, load0, rst_n, clk};
  assign bus1.io_in = {d1v, 1'b0, load1, rst_n, clk};
  assign out0 = bus0.io_out;
  assign out1 = bus1.io_out;

  hamming74_serial_tx #(.GAP_CYCLES(GAP), .POS1_FIRST(1)) u_dut0 (.io(bus0));
  hamming74_serial_tx #(.GAP_CYCLES(GAP), .POS1_FIRST(0)) u_dut1 (.io(bus1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // Reference: codeword from the parity equations, listed in transmit order (bit 6 goes out first)
  function automatic logic [6:0] model_tx(input logic [3:0] d, input logic inj, input bit pos1_first);
    logic       pos [1:7];
    logic [6:0] r;
    pos[1] = d[0] ^ d[1] ^ d[3];
    pos[2] = d[0] ^ d[2] ^ d[3];
    pos[3] = d[0] ^ inj;
    pos[4] = d[1] ^ d[2] ^ d[3];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int i = 0; i < 7; i++) begin
      r[6-i] = pos1_first ? pos[i+1] : pos[7-i];
    end
    return r;
  endfunction

  ent_t       mq [2][$];
  logic [2:0] m_par [2];
  logic       m_done [2];
  bit         m_valid = 0;
  logic [6:0] m_tx;
  logic [3:0] m_d;
  logic       m_inj;
  logic       m_load;
  ent_t       m_ent;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        m_par[k]  = 3'd0;
        m_done[k] = 1'b0;
        m_valid   = 1;
      end else if (mq[k].size() == 0) begin
        m_load = (k == 0) ? load0 : load1;
        if (m_load) begin
          m_d = (k == 0) ? d0 : d1v;
`ifdef ERROR_INJECT_EN
          m_inj = (k == 0) ? inject : 1'b0;
`else
          m_inj = 1'b0;
`endif
          m_tx = model_tx(m_d, m_inj, k == 0);
          m_par[k] = {m_d[1] ^ m_d[2] ^ m_d[3], m_d[0] ^ m_d[2] ^ m_d[3], m_d[0] ^ m_d[1] ^ m_d[3]};
          for (int i = 0; i < 7; i++) begin
            m_ent.ser   = m_tx[6-i];
            m_ent.frame = (i == 0);
            m_ent.last  = (i == 6);
            mq[k].push_back(m_ent);
          end
          for (int g = 0; g < GAP; g++) begin
            mq[k].push_back(ent_t'(3'b000));
          end
        end
      end else begin
        m_ent = mq[k].pop_front();
        if (m_ent.last) m_done[k] = ~m_done[k];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] exp_o;
        logic [7:0] got_o;
        if (mq[k].size() != 0) begin
          exp_o = {m_done[k], m_par[k], mq[k][0].last, 1'b0, mq[k][0].frame, mq[k][0].ser};
        end else begin
          exp_o = {m_done[k], m_par[k], 1'b0, 1'b1, 1'b0, 1'b0};
        end
        got_o = (k == 0) ? out0 : out1;
        tests++;
        if (got_o !== exp_o) begin
          fails++;
          $display("FAIL cycle_model dut%0d t=%0t io_out got=%b expected=%b", k, $time, got_o, exp_o);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Starts at a negedge in an idle cycle, ends at the negedge of the seventh bit
  task automatic capture_frame(input int k, input logic [3:0] dv, input logic inj,
                               output logic [6:0] s, output logic [6:0] f,
                               output logic [6:0] l, output logic [2:0] p);
    logic [7:0] o;
    if (k == 0) begin
      load0 = 1'b1; d0 = dv; inject = inj;
    end else begin
      load1 = 1'b1; d1v = dv;
    end
    s = '0; f = '0; l = '0; p = '0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) begin
        load0 = 1'b0; load1 = 1'b0; inject = 1'b0;
      end
      o = (k == 0) ? out0 : out1;
      s = {s[5:0], o[0]};
      f = {f[5:0], o[1]};
      l = {l[5:0], o[3]};
      if (i == 0) p = o[6:4];
    end
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((((k == 0) ? out0[2] : out1[2]) == 1'b0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_ready", (k == 0) ? out0[2] : out1[2], 1);
  endtask

  logic [6:0] s, f, l, s1, s2;
  logic [2:0] p;
  int         f0, f1, rlow;

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out0", out0, 8'h04);
    check("reset_out1", out1, 8'h04);

    rst_n = 1'b1;
    capture_frame(0, 4'b1011, 1'b0, s, f, l, p);
    check("d1011_ser", s, 7'b1010101);
    check("d1011_frame", f, 7'b1000000);
    check("d1011_last", l, 7'b0000001);
    check("d1011_par", p, 3'b001);
    @(negedge clk);
    check("done_after_1", out0[7], 1);
    wait_idle(0);

    capture_frame(0, 4'b0000, 1'b0, s, f, l, p);
    check("d0000_ser", s, 7'b0000000);
    check("d0000_par", p, 3'b000);
    @(negedge clk);
    check("done_after_2", out0[7], 0);
    wait_idle(0);

    capture_frame(0, 4'b1111, 1'b0, s, f, l, p);
    check("d1111_ser", s, 7'b1111111);
    check("d1111_par", p, 3'b111);
    @(negedge clk);
    check("done_after_3", out0[7], 1);
    wait_idle(0);

    // load held high; d changes mid-frame must not affect the frame in flight
    load0 = 1'b1; d0 = 4'b0110;
    f0 = -1; f1 = -1; rlow = 0; s1 = '0; s2 = '0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      if (i == 3) d0 = 4'b1001;
      if (out0[1]) begin
        if (f0 < 0) f0 = i;
        else if (f1 < 0) f1 = i;
      end
      if (i <= 10 && !out0[2]) rlow++;
      if (i <= 7) s1 = {s1[5:0], out0[0]};
      if (i >= 11 && i <= 17) s2 = {s2[5:0], out0[0]};
    end
    @(negedge clk);
    load0 = 1'b0;
    check("held_first_frame_cycle", f0, 1);
    check("held_frame_period", f1 - f0, 10);
    check("held_ready_low_cycles", rlow, 9);
    check("held_frame1_ser", s1, 7'b1100110);
    check("held_frame2_ser", s2, 7'b0011001);
    wait_idle(0);

    // reset during bit 4 of a frame
    load0 = 1'b1; d0 = 4'b1111;
    @(negedge clk);
    load0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midframe_reset_out", out0, 8'h04);
    rst_n = 1'b1;
    capture_frame(0, 4'b1011, 1'b0, s, f, l, p);
    check("after_reset_ser", s, 7'b1010101);
    check("after_reset_par", p, 3'b001);
    wait_idle(0);

    capture_frame(0, 4'b1011, 1'b1, s, f, l, p);
`ifdef ERROR_INJECT_EN
    check("inject_ser", s, 7'b1000101);
`else
    check("inject_ser", s, 7'b1010101);
`endif
    check("inject_par", p, 3'b001);
    wait_idle(0);

    capture_frame(1, 4'b0001, 1'b0, s, f, l, p);
    check("pos7first_ser", s, 7'b0000111);
    check("pos7first_frame", f, 7'b1000000);
    check("pos7first_last", l, 7'b0000001);
    check("pos7first_par", p, 3'b011);
    wait_idle(1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hamming74_serial_tx.md
HAMMING74_SERIAL_TX -- requirements
Module: hamming74_serial_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted after each frame, legal range 0..15.
REQ-002 SHALL have parameter POS1_FIRST, default 1: 1 = transmit codeword position 1 first; 0 = transmit position 7 first.
REQ-003 SHALL have port io_in[0], input, 1 bit: clk; all state changes on its rising edge.
REQ-004 SHALL have port io_in[1], input, 1 bit: rst_n; reset is synchronous and active-low.
REQ-005 SHALL have port io_in[2], input, 1 bit: load; request to encode and send the nibble on io_in[7:4].
REQ-006 SHALL have port io_in[3], input, 1 bit: inject; error-inject request, used only when ERROR_INJECT_EN is defined.
REQ-007 SHALL have port io_in[7:4], input, 4 bits: d[3:0], where d1=d[0], d2=d[1], d3=d[2] and d4=d[3].
REQ-008 SHALL have port io_out[0], output, 1 bit: ser_data, the serial codeword bit.
REQ-009 SHALL have port io_out[1], output, 1 bit: frame, high during the first bit of a frame.
REQ-010 SHALL have port io_out[2], output, 1 bit: ready, high when a load will be accepted.
REQ-011 SHALL have port io_out[3], output, 1 bit: last, high during the seventh bit of a frame.
REQ-012 SHALL have port io_out[6:4], output, 3 bits: {p4,p2,p1}, the parity bits of the frame most recently latched.
REQ-013 SHALL have port io_out[7], output, 1 bit: done_tgl, which toggles once per completed frame.

Function
REQ-014 SHALL encode Hamming(7,4), with parity bits p1=d1^d2^d4, p2=d1^d3^d4 and p4=d2^d3^d4.
REQ-015 SHALL order the codeword as positions 1..7 = p1, p2, d1, p4, d2, d3, d4.
REQ-016 SHALL implement FSM states IDLE, SHIFT and GAP; reset state is IDLE.
REQ-017 SHALL drive ready combinationally as (state==IDLE).
REQ-018 In IDLE, load=1 at a clock edge SHALL latch the 7-bit codeword and the parity outputs, clear the bit counter, and enter SHIFT.
REQ-019 SHALL make ser_data, frame and last registered; the first bit is valid in the cycle immediately after the accepting edge (1-cycle latency).
REQ-020 SHIFT SHALL last exactly 7 cycles, bit counter 0..6; frame=1 only at count 0 and last=1 only at count 6.
REQ-021 After count 6, the FSM SHALL enter GAP for GAP_CYCLES cycles, or go directly to IDLE if GAP_CYCLES=0.
REQ-022 done_tgl SHALL toggle on the edge that leaves count 6.
REQ-023 ser_data, frame and last SHALL be 0 in IDLE and GAP.
REQ-024 load while not IDLE SHALL be ignored, with no queueing; the latched codeword and parity outputs SHALL be held unchanged during SHIFT and GAP.
REQ-025 load held high continuously SHALL start a new frame on every return to IDLE, giving a frame period of 7+GAP_CYCLES+1 cycles.
REQ-026 d and inject SHALL be sampled only on the accepting edge; changes during SHIFT SHALL have no effect.

Reset
REQ-027 rst_n=0 at an edge SHALL force IDLE, bit counter=0, codeword=0, ser_data=0, frame=0, last=0, io_out[6:4]=0 and done_tgl=0, including mid-frame.
REQ-028 After reset, ready=1 in the first cycle; a load sampled on the first edge with rst_n=1 SHALL be accepted.

Configuration
REQ-029 With macro ERROR_INJECT_EN defined, inject=1 on the accepting edge SHALL invert codeword position 3 (d1) in the transmitted bits only; io_out[6:4] SHALL still show the correct parity.
REQ-030 Without ERROR_INJECT_EN, inject SHALL be ignored and no inject logic SHALL be synthesized.

Structure
REQ-031 Shared package hamming_pkg SHALL hold: the state enum (IDLE, SHIFT, GAP), constant CW_BITS=7, constant DATA_BITS=4, and the codeword position-order constants.
REQ-032 The combinational encoder SHALL be a sub-module hamming74_enc (d[3:0] in, cw[6:0] out); the FSM and shifter SHALL reside in the top module.

Verification
REQ-033 Bench SHALL cover: reset, then load=1 for 1 cycle with d=4'b1011 and POS1_FIRST=1 -> ser_data 1,0,1,0,1,0,1 on the next 7 cycles; frame on cycle 1; last on cycle 7; io_out[6:4]=3'b001.
REQ-034 Bench SHALL cover: d=4'b0000 -> all 7 bits 0, parity 000; d=4'b1111 -> all 7 bits 1, parity 111; done_tgl toggles after each frame.
REQ-035 Bench SHALL cover: load held high with GAP_CYCLES=2 -> frames start every 10 cycles, ready low for 9 cycles, and mid-frame changes on d are ignored.
REQ-036 Bench SHALL cover: rst_n=0 at bit 4 of a frame -> next cycle ser_data=0, frame=0, last=0, ready=1, io_out[6:4]=0; a new load is then accepted normally.
REQ-037 Bench SHALL cover: with ERROR_INJECT_EN defined, d=4'b1011 and inject=1 -> ser_data 1,0,0,0,1,0,1 and parity 001; without the macro, the same stimulus -> 1,0,1,0,1,0,1.
REQ-038 Bench SHALL cover: POS1_FIRST=0 with d=4'b0001 -> codeword positions 1..7 = 1,1,1,0,0,0,0, transmitted as 0,0,0,0,1,1,1.
